// File: rtl/audio_pkg.sv
// Types and constants shared by the microphone front-end blocks.
package audio_pkg;

    localparam int NUM_MICS = 3;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LOAD    = 2'd2,
        STALL   = 2'd3
    } aligner_state_t;

endpackage

// File: rtl/mic_frame_aligner_if.sv
// Mic sample inputs and framed output handshake of mic_frame_aligner.
interface mic_frame_aligner_if #(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
);
    logic [audio_pkg::NUM_MICS-1:0]          mic_valid_in;
    logic [audio_pkg::NUM_MICS*SAMPLE_W-1:0] mic_data_in;
    logic                                    frame_valid_out;
    logic                                    frame_ready_in;
    logic [audio_pkg::NUM_MICS*SAMPLE_W-1:0] frame_data_out;
    logic [audio_pkg::NUM_MICS-1:0]          missing_out;
    logic [audio_pkg::NUM_MICS-1:0]          overrun_out;
    logic [15:0]                             frame_count_out;

    // Upstream receivers plus downstream consumer.
    modport master (
        output mic_valid_in, mic_data_in, frame_ready_in,
        input  frame_valid_out, frame_data_out, missing_out, overrun_out, frame_count_out
    );

    // The aligner itself.
    modport slave (
        input  mic_valid_in, mic_data_in, frame_ready_in,
        output frame_valid_out, frame_data_out, missing_out, overrun_out, frame_count_out
    );
endinterface

// File: rtl/mic_slot.sv
// One microphone slot: latest sample, pending flag and sticky overrun flag.
module mic_slot #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [W-1:0] data,
    input  logic         clear,
    output logic [W-1:0] sample,
    output logic         pending,
    output logic         overrun
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample  <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            // A new sample beats a simultaneous clear: it opens the next frame.
            if (valid) begin
                sample  <= data;
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
            // Overwriting on the clear edge is fine: the old sample is framed then.
            if (valid && pending && !clear) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mic_frame_aligner.sv
// Aligns three independently strobed mic samples into one frame, zero-filling
// slots that miss the timeout, and presents frames on a valid/ready handshake.
module mic_frame_aligner #(
    parameter int SAMPLE_W       = audio_pkg::SAMPLE_W,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                clk_in,
    input logic                rst_in,
    mic_frame_aligner_if.slave bus
);
    import audio_pkg::NUM_MICS;
    import audio_pkg::aligner_state_t;
    import audio_pkg::IDLE;
    import audio_pkg::COLLECT;
    import audio_pkg::LOAD;
    import audio_pkg::STALL;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SAMPLE_W-1:0]          sample [NUM_MICS];
    logic [NUM_MICS-1:0]          pending;
    logic [NUM_MICS-1:0]          overrun;
    logic [NUM_MICS-1:0]          arrived;
    logic                         clear;
    logic                         load;
    logic                         out_free;
    logic [NUM_MICS*SAMPLE_W-1:0] load_data;

    aligner_state_t               state, state_d;
    logic [CNT_W-1:0]             cnt, cnt_d;
    logic                         out_valid;
    logic [NUM_MICS*SAMPLE_W-1:0] out_data;
    logic [NUM_MICS-1:0]          out_missing;
    logic [15:0]                  frame_count;

    for (genvar i = 0; i < NUM_MICS; i++) begin : g_slot
        mic_slot #(
            .W (SAMPLE_W)
        ) u_slot (
            .clk     (clk_in),
            .rst     (rst_in),
            .valid   (bus.mic_valid_in[i]),
            .data    (bus.mic_data_in[i*SAMPLE_W +: SAMPLE_W]),
            .clear   (clear),
            .sample  (sample[i]),
            .pending (pending[i]),
            .overrun (overrun[i])
        );
    end

    assign out_free = !out_valid || bus.frame_ready_in;
    // Completion counts samples landing this edge so LOAD follows the last one directly.
    assign arrived  = pending | bus.mic_valid_in;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        clear   = 1'b0;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|bus.mic_valid_in) begin
                    cnt_d   = '0;
                    state_d = (&arrived) ? LOAD : COLLECT;
                end
            end
            COLLECT: begin
                cnt_d = cnt + 1'b1;
                if ((&arrived) || (cnt == CNT_LAST)) begin
                    state_d = LOAD;
                end
            end
            LOAD, STALL: begin
                if (out_free) begin
                    load    = 1'b1;
                    clear   = 1'b1;
                    cnt_d   = '0;
                    state_d = (|bus.mic_valid_in) ? COLLECT : IDLE;
                end else begin
                    state_d = STALL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_data = '0;
        for (int i = 0; i < NUM_MICS; i++) begin
            if (pending[i]) begin
                load_data[i*SAMPLE_W +: SAMPLE_W] = sample[i];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_missing <= '0;
            frame_count <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (load) begin
                out_valid   <= 1'b1;
                out_data    <= load_data;
                out_missing <= ~pending;
            end else if (out_valid && bus.frame_ready_in) begin
                out_valid <= 1'b0;
            end
            if (out_valid && bus.frame_ready_in) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    assign bus.frame_valid_out = out_valid;
    assign bus.frame_data_out  = out_data;
    assign bus.missing_out     = out_missing;
    assign bus.overrun_out     = overrun;
    assign bus.frame_count_out = frame_count;

endmodule

// File: tb/tb_mic_frame_aligner.sv
// Directed bench for mic_frame_aligner: alignment, backpressure, timeout,
// overrun, set-beats-clear and asynchronous reset.
module tb_mic_frame_aligner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mic_frame_aligner_if #(.SAMPLE_W(16)) bus ();

    mic_frame_aligner #(
        .SAMPLE_W       (16),
        .TIMEOUT_CYCLES (4096)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle strobe; returns just after the capturing edge.
    task automatic pulse(input logic [2:0] mask, input logic [47:0] data);
        bus.mic_valid_in = mask;
        bus.mic_data_in  = data;
        tick();
        bus.mic_valid_in = 3'b000;
    endtask

    initial begin
        bus.mic_valid_in   = 3'b000;
        bus.mic_data_in    = '0;
        bus.frame_ready_in = 1'b0;
        #2;
        check_eq("rst_valid", 64'(bus.frame_valid_out), 64'd0);
        check_eq("rst_data", 64'(bus.frame_data_out), 64'd0);
        check_eq("rst_missing", 64'(bus.missing_out), 64'd0);
        check_eq("rst_overrun", 64'(bus.overrun_out), 64'd0);
        check_eq("rst_count", 64'(bus.frame_count_out), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Backpressure: all three together, consumer holds off for 20 cycles.
        pulse(3'b111, 48'h0C0C_0B0B_0A0A);
        check_eq("bp_not_yet", 64'(bus.frame_valid_out), 64'd0);
        tick();
        check_eq("bp_valid", 64'(bus.frame_valid_out), 64'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("bp_hold_valid", 64'(bus.frame_valid_out), 64'd1);
            check_eq("bp_hold_data", 64'(bus.frame_data_out), 64'h0C0C_0B0B_0A0A);
        end
        check_eq("bp_count_before", 64'(bus.frame_count_out), 64'd0);
        bus.frame_ready_in = 1'b1;
        tick();
        check_eq("bp_drop", 64'(bus.frame_valid_out), 64'd0);
        check_eq("bp_count_after", 64'(bus.frame_count_out), 64'd1);

        // Staggered arrival, 15 cycles apart.
        pulse(3'b001, 48'h0000_0000_1111);
        repeat (14) tick();
        pulse(3'b010, 48'h0000_2222_0000);
        repeat (14) tick();
        pulse(3'b100, 48'h3333_0000_0000);
        check_eq("al_not_yet", 64'(bus.frame_valid_out), 64'd0);
        tick();
        check_eq("al_valid", 64'(bus.frame_valid_out), 64'd1);
        check_eq("al_data", 64'(bus.frame_data_out), 64'h3333_2222_1111);
        check_eq("al_missing", 64'(bus.missing_out), 64'd0);
        tick();
        check_eq("al_one_cycle", 64'(bus.frame_valid_out), 64'd0);
        check_eq("al_count", 64'(bus.frame_count_out), 64'd2);

        // Mic 3 dead: the frame is forced out after the timeout.
        pulse(3'b011, 48'h0000_5678_1234);
        repeat (4096) tick();
        check_eq("to_not_yet", 64'(bus.frame_valid_out), 64'd0);
        tick();
        check_eq("to_valid", 64'(bus.frame_valid_out), 64'd1);
        check_eq("to_data", 64'(bus.frame_data_out), 64'h0000_5678_1234);
        check_eq("to_missing", 64'(bus.missing_out), 64'b100);
        tick();
        check_eq("to_count", 64'(bus.frame_count_out), 64'd3);

        // Mic 2 overwritten before the frame completes.
        pulse(3'b010, 48'h0000_AAAA_0000);
        tick();
        tick();
        pulse(3'b010, 48'h0000_BBBB_0000);
        check_eq("ov_flag", 64'(bus.overrun_out), 64'b010);
        pulse(3'b101, 48'h0303_0000_0101);
        tick();
        check_eq("ov_valid", 64'(bus.frame_valid_out), 64'd1);
        check_eq("ov_data", 64'(bus.frame_data_out), 64'h0303_BBBB_0101);
        check_eq("ov_missing", 64'(bus.missing_out), 64'd0);
        tick();
        check_eq("ov_sticky", 64'(bus.overrun_out), 64'b010);
        check_eq("ov_count", 64'(bus.frame_count_out), 64'd4);

        // Stalled complete frame; a new mic 1 sample lands on the load edge.
        bus.frame_ready_in = 1'b0;
        pulse(3'b111, 48'h0003_0002_0001);
        tick();
        pulse(3'b111, 48'h0006_0005_0004);
        tick();
        tick();
        check_eq("st_held", 64'(bus.frame_data_out), 64'h0003_0002_0001);
        bus.frame_ready_in = 1'b1;
        pulse(3'b001, 48'h0000_0000_7777);
        check_eq("st_next_valid", 64'(bus.frame_valid_out), 64'd1);
        check_eq("st_next_data", 64'(bus.frame_data_out), 64'h0006_0005_0004);
        check_eq("st_collect", 64'(dut.state), 64'(audio_pkg::COLLECT));
        check_eq("st_count", 64'(bus.frame_count_out), 64'd5);
        pulse(3'b110, 48'h9999_8888_0000);
        tick();
        check_eq("st_kept_valid", 64'(bus.frame_valid_out), 64'd1);
        check_eq("st_kept_data", 64'(bus.frame_data_out), 64'h9999_8888_7777);
        check_eq("st_kept_missing", 64'(bus.missing_out), 64'd0);
        tick();
        check_eq("st_overrun", 64'(bus.overrun_out), 64'b010);
        check_eq("st_count2", 64'(bus.frame_count_out), 64'd7);

        // Reset mid-COLLECT with a frame still presented.
        bus.frame_ready_in = 1'b0;
        pulse(3'b111, 48'h000C_000B_000A);
        tick();
        pulse(3'b001, 48'h0000_0000_0055);
        tick();
        rst = 1'b1;
        #1;
        check_eq("ar_valid", 64'(bus.frame_valid_out), 64'd0);
        check_eq("ar_data", 64'(bus.frame_data_out), 64'd0);
        check_eq("ar_missing", 64'(bus.missing_out), 64'd0);
        check_eq("ar_overrun", 64'(bus.overrun_out), 64'd0);
        check_eq("ar_count", 64'(bus.frame_count_out), 64'd0);
        tick();
        rst = 1'b0;
        bus.frame_ready_in = 1'b1;
        pulse(3'b110, 48'h0022_0011_0000);
        tick();
        check_eq("ar_pend_gone", 64'(bus.frame_valid_out), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
